led_matrix_scan_driver: RTL and testbench



---
 rtl/led_matrix_scan_driver_if.sv | 26 ++
 rtl/led_matrix_scan_driver.sv | 151 +++++++++++++++
 tb/tb_led_matrix_scan_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_scan_driver_if.sv
// rtl/led_matrix_scan_driver_if.sv - host and matrix-pin signal bundle for the LED scan driver
interface led_matrix_scan_driver_if #(
   parameter int ROWS = 6,
   parameter int COLS = 6,
   parameter int RW   = $clog2(ROWS)
);
   logic            enable;
   logic            wr_en;
   logic [RW-1:0]   wr_row;
   logic [COLS-1:0] wr_data;
   logic            swap_req;
   logic            swap_pending;
   logic            frame_start;
   logic [ROWS-1:0] row_n;
   logic [COLS-1:0] col_n;

   modport master (
      output enable, wr_en, wr_row, wr_data, swap_req,
      input  swap_pending, frame_start, row_n, col_n
   );

   modport slave (
      input  enable, wr_en, wr_row, wr_data, swap_req,
      output swap_pending, frame_start, row_n, col_n
   );
endinterface

// File: rtl/led_matrix_scan_driver.sv
// rtl/led_matrix_scan_driver.sv - double-buffered, row-scanned driver for an active-low LED matrix
module led_matrix_scan_driver #(
   parameter int ROWS  = 6,
   parameter int COLS  = 6,
   parameter int DWELL = 1000,
   parameter int BLANK = 2,
   parameter int RW    = $clog2(ROWS)
) (
   input logic                  clk,
   input logic                  rst_n,
   led_matrix_scan_driver_if.slave bus
);
   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BLANK} state_t;

   state_t          state, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            front_sel, front_sel_d;
   logic            swap_pending_q, swap_pending_d;
   logic [COLS-1:0] buf0 [ROWS];
   logic [COLS-1:0] buf1 [ROWS];

   logic [ROWS-1:0] row_n_q, row_n_d;
   logic [COLS-1:0] col_n_q, col_n_d;
   logic            frame_start_q, frame_start_d;

   logic            enter_row0;
   logic            do_swap;
   logic            wr_ok;
   logic [COLS-1:0] front_row;
   logic [COLS-1:0] row_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         row_q <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_d;
         row_q <= row_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      row_d   = row_q;
      cnt_d   = cnt_q;
      if (!bus.enable) begin
         state_d = S_IDLE;
         row_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               state_d = S_DRIVE;
               row_d   = '0;
               cnt_d   = '0;
            end
            S_DRIVE: begin
               if (cnt_q == DWELL_LAST) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_DRIVE;
                  cnt_d   = '0;
                  row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               row_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // A swap lands only on the edge that enters DRIVE(0), so a displayed frame never tears.
   always_comb begin
      enter_row0     = (state_d == S_DRIVE) && (state != S_DRIVE) && (row_d == '0);
      do_swap        = enter_row0 && swap_pending_q;
      front_sel_d    = front_sel ^ do_swap;
      swap_pending_d = (swap_pending_q && !do_swap) || bus.swap_req;
      wr_ok          = bus.wr_en && (32'(bus.wr_row) < ROWS);
      front_row      = front_sel_d ? buf1[row_d] : buf0[row_d];
      // A write on the swap edge targets the buffer that is about to be shown, so forward it.
      row_data       = (do_swap && wr_ok && (bus.wr_row == row_d)) ? bus.wr_data : front_row;
   end

   always_comb begin
      row_n_d       = '1;
      col_n_d       = '1;
      frame_start_d = enter_row0;
      if (state_d == S_DRIVE) begin
         row_n_d = ~(ROWS'(1) << row_d);
         col_n_d = ~row_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         front_sel      <= 1'b0;
         swap_pending_q <= 1'b0;
         row_n_q        <= '1;
         col_n_q        <= '1;
         frame_start_q  <= 1'b0;
      end else begin
         front_sel      <= front_sel_d;
         swap_pending_q <= swap_pending_d;
         row_n_q        <= row_n_d;
         col_n_q        <= col_n_d;
         frame_start_q  <= frame_start_d;
      end
   end

   // Writes always go to the back buffer as seen before this edge's swap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROWS; i++) begin
            buf0[i] <= '0;
            buf1[i] <= '0;
         end
      end else if (wr_ok) begin
         if (front_sel) begin
            buf0[bus.wr_row] <= bus.wr_data;
         end else begin
            buf1[bus.wr_row] <= bus.wr_data;
         end
      end
   end

   assign bus.row_n        = row_n_q;
   assign bus.col_n        = col_n_q;
   assign bus.frame_start  = frame_start_q;
   assign bus.swap_pending = swap_pending_q;
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb/tb_led_matrix_scan_driver.sv - scoreboard bench for the LED matrix scan driver
module tb_led_matrix_scan_driver;
   localparam int R   = 6;
   localparam int C   = 6;
   localparam int DW  = 4;
   localparam int BL  = 1;
   localparam int PER = R * (DW + BL);

   typedef struct packed {
      logic [R-1:0] rn;
      logic [C-1:0] cn;
      logic         fs;
      logic         sp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   cyc_no = 0;

   exp_t sb[$];

   bit           running;
   int           phase;
   bit           pend;
   logic [C-1:0] fm [R];
   logic [C-1:0] bm [R];

   led_matrix_scan_driver_if #(.ROWS(R), .COLS(C)) bus ();

   led_matrix_scan_driver #(.ROWS(R), .COLS(C), .DWELL(DW), .BLANK(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      running = 0;
      phase   = 0;
      pend    = 0;
      for (int i = 0; i < R; i++) begin
         fm[i] = '0;
         bm[i] = '0;
      end
   endtask

   // Reference: scan position is a single phase counter within the frame period.
   task automatic model_edge(input bit en, input bit wr, input int wrow,
                             input logic [C-1:0] wd, input bit sreq);
      bit           sw_edge;
      logic [C-1:0] tmp [R];
      exp_t         e;
      int           r;
      if (!en) running = 0;
      else if (!running) begin
         running = 1;
         phase   = 0;
      end else phase = (phase + 1) % PER;
      sw_edge = running && (phase == 0);
      if (wr && wrow < R) bm[wrow] = wd;
      if (sw_edge && pend) begin
         tmp = fm;
         fm  = bm;
         bm  = tmp;
      end
      pend = (pend && !sw_edge) || sreq;
      e.rn = '1;
      e.cn = '1;
      if (running && (phase % (DW + BL)) < DW) begin
         r    = phase / (DW + BL);
         e.rn = ~(R'(1) << r);
         e.cn = ~fm[r];
      end
      e.fs = sw_edge;
      e.sp = pend;
      sb.push_back(e);
   endtask

   task automatic cyc(input bit en, input bit wr, input int wrow,
                      input logic [C-1:0] wd, input bit sreq);
      bus.enable   = en;
      bus.wr_en    = wr;
      bus.wr_row   = 3'(wrow);
      bus.wr_data  = wd;
      bus.swap_req = sreq;
      @(posedge clk);
      model_edge(en, wr, wrow, wd, sreq);
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, 0);
   endtask

   task automatic run_to_phase(input int target);
      int n = 0;
      while (!(running && phase == target) && n < PER + 5) begin
         cyc(1, 0, 0, '0, 0);
         n++;
      end
      checks++;
      if (!(running && phase == target)) begin
         errors++;
         $display("FAIL run_to_phase: got phase %0d want %0d", phase, target);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cyc_no++;
         check_val($sformatf("row_n@%0d", cyc_no), 32'(bus.row_n), 32'(e.rn));
         check_val($sformatf("col_n@%0d", cyc_no), 32'(bus.col_n), 32'(e.cn));
         check_val($sformatf("frame_start@%0d", cyc_no), 32'(bus.frame_start), 32'(e.fs));
         check_val($sformatf("swap_pending@%0d", cyc_no), 32'(bus.swap_pending), 32'(e.sp));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bus.enable   = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_row   = '0;
      bus.wr_data  = '0;
      bus.swap_req = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_val("reset row_n", 32'(bus.row_n), 32'h3f);
      check_val("reset col_n", 32'(bus.col_n), 32'h3f);
      check_val("reset frame_start", 32'(bus.frame_start), 32'h0);
      check_val("reset swap_pending", 32'(bus.swap_pending), 32'h0);
      rst_n = 1'b1;

      // empty buffers scan
      run(35);

      // back[2] = 101001 then swap
      cyc(1, 1, 2, 6'b101001, 0);
      cyc(1, 0, 0, '0, 1);
      run_to_phase(PER - 1);
      run(61);

      // mid-frame write without swap, then swap
      run_to_phase(10);
      cyc(1, 1, 0, 6'b111111, 0);
      run_to_phase(PER - 2);
      cyc(1, 0, 0, '0, 1);
      run(40);

      // repeated requests, one exactly on the swap edge
      run_to_phase(5);
      cyc(1, 0, 0, '0, 1);
      cyc(1, 0, 0, '0, 0);
      cyc(1, 0, 0, '0, 1);
      run_to_phase(PER - 1);
      cyc(1, 1, 0, 6'b000111, 1);
      run(35);

      // drop enable during DRIVE(3) with a swap pending
      cyc(1, 1, 1, 6'b110011, 1);
      run_to_phase(3 * (DW + BL) + 1);
      repeat (4) cyc(0, 0, 0, '0, 0);
      cyc(1, 0, 0, '0, 0);
      run(12);

      // asynchronous reset mid-DRIVE
      run_to_phase(7);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async reset row_n", 32'(bus.row_n), 32'h3f);
      check_val("async reset col_n", 32'(bus.col_n), 32'h3f);
      check_val("async reset swap_pending", 32'(bus.swap_pending), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1, 1, 7, 6'b111111, 0);
      cyc(1, 0, 0, '0, 1);
      run(40);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0,
             int'($urandom_range(0, 7)), C'($urandom), $urandom_range(0, 9) == 0);
      end

      @(negedge clk);
      #1;
      check_val("scoreboard drained", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
